// File: rtl/imm_gen_pipe.sv
`default_nettype none
// ============================================================================
// Module   : imm_gen_pipe
// Purpose  : Pipelined RISC-V immediate generator. Decodes the immediate of
//            every RV32I/RV64I format (I, S, B, J, U, CSR zimm, shamt),
//            registers it together with a sideband tag, and hands it to the
//            execute stage over a valid/ready handshake backed by a 2-entry
//            skid buffer (main + skid). A synchronous flush empties both.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   XLEN   datapath width, 32 or 64
//   TAG_W  sideband tag width
// Ports
//   clk        in   rising-edge clock
//   resetn     in   asynchronous active-low reset
//   flush      in   synchronous drop of all buffered entries
//   in_valid   in   instr / imm_src / in_tag valid
//   in_ready   out  input can be accepted this cycle (registered)
//   instr      in   32-bit instruction word
//   imm_src    in   format select (I,S,B,J,U,Z,SH,none)
//   in_tag     in   sideband tag (PC / ROB id)
//   out_valid  out  imm_ext / out_tag valid
//   out_ready  in   consumer takes the output this cycle
//   imm_ext    out  extended immediate
//   out_tag    out  tag belonging to imm_ext
//   bad_src    out  sticky: an entry with format "none" was accepted
// Build option
//   IMM_GEN_AUTODECODE_EN  when defined, imm_src is ignored and the format
//                          is decoded from the opcode/funct3 of instr.
// ============================================================================
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [2:0]       imm_src,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm_ext,
  output logic [TAG_W-1:0] out_tag,
  output logic             bad_src
);

  localparam logic [2:0] FMT_I    = 3'b000;
  localparam logic [2:0] FMT_S    = 3'b001;
  localparam logic [2:0] FMT_B    = 3'b010;
  localparam logic [2:0] FMT_J    = 3'b011;
  localparam logic [2:0] FMT_U    = 3'b100;
  localparam logic [2:0] FMT_Z    = 3'b101;
  localparam logic [2:0] FMT_SH   = 3'b110;
  localparam logic [2:0] FMT_NONE = 3'b111;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   main_imm_q, main_imm_d;
  logic [XLEN-1:0]   skid_imm_q, skid_imm_d;
  logic [TAG_W-1:0]  main_tag_q, main_tag_d;
  logic [TAG_W-1:0]  skid_tag_q, skid_tag_d;
  logic              bad_src_q, bad_src_d;

  logic [2:0]        fmt;
  logic signed [31:0] imm_s32;
  logic [5:0]        imm_zext;
  logic              use_zext;
  logic [XLEN-1:0]   imm_new;
  logic              accept;
  logic              xfer;

  // --------------------------------------------------------------------------
  // Format selection
  // --------------------------------------------------------------------------
`ifdef IMM_GEN_AUTODECODE_EN
  logic unused_src;
  assign unused_src = ^imm_src;

  always_comb begin
    fmt = FMT_NONE;
    case (instr[6:0])
      // OP-IMM: funct3 001 (SLLI) / 101 (SRLI/SRAI) carry a shift amount
      7'b0010011: fmt = (instr[13:12] == 2'b01) ? FMT_SH : FMT_I;
      7'b0000011,
      7'b1100111: fmt = FMT_I;
      7'b0100011: fmt = FMT_S;
      7'b1100011: fmt = FMT_B;
      7'b1101111: fmt = FMT_J;
      7'b0110111,
      7'b0010111: fmt = FMT_U;
      // SYSTEM: only the CSR*I forms (funct3[2]=1) carry a zimm
      7'b1110011: fmt = instr[14] ? FMT_Z : FMT_NONE;
      default:    fmt = FMT_NONE;
    endcase
  end
`else
  logic unused_opcode;
  assign unused_opcode = ^instr[6:0];
  assign fmt           = imm_src;
`endif

  // --------------------------------------------------------------------------
  // Immediate extraction. Sign-extended formats are built as a 32-bit signed
  // value and then widened by replicating bit 31, which covers XLEN=32 and
  // XLEN=64 without zero-width replications.
  // --------------------------------------------------------------------------
  always_comb begin
    imm_s32  = '0;
    imm_zext = '0;
    use_zext = 1'b0;
    case (fmt)
      FMT_I:  imm_s32 = {{20{instr[31]}}, instr[31:20]};
      FMT_S:  imm_s32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B:  imm_s32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                         instr[11:8], 1'b0};
      FMT_J:  imm_s32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                         instr[30:21], 1'b0};
      FMT_U:  imm_s32 = {instr[31:12], 12'b0};
      FMT_Z: begin
        use_zext = 1'b1;
        imm_zext = {1'b0, instr[19:15]};
      end
      FMT_SH: begin
        use_zext = 1'b1;
        // RV64 shifts use a 6-bit shamt; RV32 only 5 bits
        imm_zext = (XLEN == 64) ? instr[25:20] : {1'b0, instr[24:20]};
      end
      default: ;  // "none" yields zero
    endcase

    if (use_zext) begin
      imm_new      = '0;
      imm_new[5:0] = imm_zext;
    end else begin
      imm_new       = {XLEN{imm_s32[31]}};
      imm_new[31:0] = imm_s32;
    end
  end

  // --------------------------------------------------------------------------
  // Handshake / skid buffer. in_ready and out_valid decode the registered
  // state only, so there is no combinational path from out_ready to in_ready.
  // --------------------------------------------------------------------------
  assign in_ready  = (state_q != S_TWO);
  assign out_valid = (state_q != S_EMPTY);
  assign imm_ext   = main_imm_q;
  assign out_tag   = main_tag_q;
  assign bad_src   = bad_src_q;

  // A flushed cycle never accepts, so a flushed "none" does not set bad_src
  assign accept = in_valid && in_ready && !flush;
  assign xfer   = out_valid && out_ready;

  always_comb begin
    state_d    = state_q;
    main_imm_d = main_imm_q;
    main_tag_d = main_tag_q;
    skid_imm_d = skid_imm_q;
    skid_tag_d = skid_tag_q;
    bad_src_d  = bad_src_q | (accept && (fmt == FMT_NONE));

    if (flush) begin
      state_d = S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (accept) begin
            main_imm_d = imm_new;
            main_tag_d = in_tag;
            state_d    = S_ONE;
          end
        end
        S_ONE: begin
          if (accept && xfer) begin
            main_imm_d = imm_new;
            main_tag_d = in_tag;
          end else if (accept) begin
            skid_imm_d = imm_new;
            skid_tag_d = in_tag;
            state_d    = S_TWO;
          end else if (xfer) begin
            state_d    = S_EMPTY;
          end
        end
        S_TWO: begin
          if (xfer) begin
            main_imm_d = skid_imm_q;
            main_tag_d = skid_tag_q;
            state_d    = S_ONE;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_EMPTY;
      main_imm_q <= '0;
      main_tag_q <= '0;
      skid_imm_q <= '0;
      skid_tag_q <= '0;
      bad_src_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      main_imm_q <= main_imm_d;
      main_tag_q <= main_tag_d;
      skid_imm_q <= skid_imm_d;
      skid_tag_q <= skid_tag_d;
      bad_src_q  <= bad_src_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_imm_gen_pipe
// Purpose  : Self-checking bench for imm_gen_pipe. Drives an XLEN=32 and an
//            XLEN=64 instance from the same stimulus. A scoreboard queue is
//            filled with model-computed immediates when an input is accepted
//            and drained/compared when an output transfer occurs; scenario
//            tasks additionally check handshake state and known vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        resetn;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] instr;
  logic [2:0]  imm_src;
  logic [31:0] in_tag;

  logic        in_ready32, out_valid32, bad32;
  logic [31:0] imm32, tag32;
  logic        in_ready64, out_valid64, bad64;
  logic [63:0] imm64;
  logic [31:0] tag64;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] e32;
    logic [63:0] e64;
    logic [31:0] tag;
  } exp_t;

  exp_t sb[$];
  exp_t e_pop;
  logic [63:0] mon_m32, mon_m64;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(32)) dut32 (
    .clk(clk), .resetn(resetn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready32),
    .instr(instr), .imm_src(imm_src), .in_tag(in_tag),
    .out_valid(out_valid32), .out_ready(out_ready),
    .imm_ext(imm32), .out_tag(tag32), .bad_src(bad32)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
    .clk(clk), .resetn(resetn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready64),
    .instr(instr), .imm_src(imm_src), .in_tag(in_tag),
    .out_valid(out_valid64), .out_ready(out_ready),
    .imm_ext(imm64), .out_tag(tag64), .bad_src(bad64)
  );

  // Reference immediate, written directly from the format table
  function automatic logic [63:0] model(input logic [31:0] i,
                                        input logic [2:0] s,
                                        input bit x64);
    case (s)
      3'b000: model = {{52{i[31]}}, i[31:20]};
      3'b001: model = {{52{i[31]}}, i[31:25], i[11:7]};
      3'b010: model = {{51{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      3'b011: model = {{43{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      3'b100: model = {{32{i[31]}}, i[31:12], 12'b0};
      3'b101: model = {59'b0, i[19:15]};
      3'b110: model = x64 ? {58'b0, i[25:20]} : {59'b0, i[24:20]};
      default: model = 64'b0;
    endcase
  endfunction

  // Scoreboard: sampled on the falling edge, i.e. with the values that the
  // next rising edge will act on.
  always @(negedge clk) begin
    if (resetn !== 1'b1) begin
      sb.delete();
    end else begin
      if (out_valid32 && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected_output imm32=%h tag=%h expected none", imm32, tag32);
        end else begin
          e_pop = sb.pop_front();
          checks++;
          if (imm32 !== e_pop.e32 || tag32 !== e_pop.tag) begin
            failures++;
            $display("FAIL sb_out32 got imm=%h tag=%h expected imm=%h tag=%h",
                     imm32, tag32, e_pop.e32, e_pop.tag);
          end
          checks++;
          if (out_valid64 !== 1'b1 || imm64 !== e_pop.e64 || tag64 !== e_pop.tag) begin
            failures++;
            $display("FAIL sb_out64 got v=%b imm=%h tag=%h expected v=1 imm=%h tag=%h",
                     out_valid64, imm64, tag64, e_pop.e64, e_pop.tag);
          end
        end
      end
      if (flush) begin
        sb.delete();
      end else if (in_valid && in_ready32) begin
        mon_m32 = model(instr, imm_src, 1'b0);
        mon_m64 = model(instr, imm_src, 1'b1);
        sb.push_back('{e32: mon_m32[31:0], e64: mon_m64, tag: in_tag});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] i, input logic [2:0] s, input logic [31:0] t);
    in_valid = 1'b1;
    instr    = i;
    imm_src  = s;
    in_tag   = t;
  endtask

  task automatic test_reset();
    resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    instr = '0; imm_src = '0; in_tag = '0;
    tick(); tick();
    checks++;
    if (in_ready32 !== 1'b1 || out_valid32 !== 1'b0 || imm32 !== 32'h0 ||
        tag32 !== 32'h0 || bad32 !== 1'b0) begin
      failures++;
      $display("FAIL reset32 got rdy=%b v=%b imm=%h tag=%h bad=%b expected 1 0 0 0 0",
               in_ready32, out_valid32, imm32, tag32, bad32);
    end
    checks++;
    if (in_ready64 !== 1'b1 || out_valid64 !== 1'b0 || imm64 !== 64'h0 || bad64 !== 1'b0) begin
      failures++;
      $display("FAIL reset64 got rdy=%b v=%b imm=%h bad=%b expected 1 0 0 0",
               in_ready64, out_valid64, imm64, bad64);
    end
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_format_i();
    out_ready = 1'b1;
    drive(32'hFFF00093, 3'b000, 32'h100);
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid32 !== 1'b1 || imm32 !== 32'hFFFFFFFF || tag32 !== 32'h100) begin
      failures++;
      $display("FAIL fmt_i got v=%b imm=%h tag=%h expected v=1 imm=ffffffff tag=00000100",
               out_valid32, imm32, tag32);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    drive(32'hFE000EE3, 3'b010, 32'h11);
    tick();
    checks++;
    if (imm32 !== 32'hFFFFFFFC || in_ready32 !== 1'b1 || out_valid32 !== 1'b1) begin
      failures++;
      $display("FAIL b2b_b got imm=%h rdy=%b v=%b expected imm=fffffffc rdy=1 v=1",
               imm32, in_ready32, out_valid32);
    end
    drive(32'h0080006F, 3'b011, 32'h12);
    tick();
    in_valid = 1'b0;
    checks++;
    if (imm32 !== 32'h00000008 || in_ready32 !== 1'b1 || out_valid32 !== 1'b1) begin
      failures++;
      $display("FAIL b2b_j got imm=%h rdy=%b v=%b expected imm=00000008 rdy=1 v=1",
               imm32, in_ready32, out_valid32);
    end
    tick();
    checks++;
    if (out_valid32 !== 1'b0) begin
      failures++;
      $display("FAIL b2b_drained got v=%b expected 0", out_valid32);
    end
  endtask

  task automatic test_xlen64();
    out_ready = 1'b1;
    drive(32'h800000B7, 3'b100, 32'h21);
    tick();
    checks++;
    if (imm64 !== 64'hFFFFFFFF80000000 || imm32 !== 32'h80000000) begin
      failures++;
      $display("FAIL x64_u got imm64=%h imm32=%h expected ffffffff80000000 80000000",
               imm64, imm32);
    end
    drive(32'h03F0D093, 3'b110, 32'h22);
    tick();
    in_valid = 1'b0;
    checks++;
    if (imm64 !== 64'h000000000000003F || imm32 !== 32'h0000001F) begin
      failures++;
      $display("FAIL x64_sh got imm64=%h imm32=%h expected 000000000000003f 0000001f",
               imm64, imm32);
    end
    tick();
  endtask

  task automatic test_skid();
    logic [31:0] w [3];
    logic [2:0]  s [3];
    logic [63:0] m;
    for (int k = 0; k < 3; k++) begin
      w[k] = $urandom;
      s[k] = 3'($urandom_range(0, 6));
    end
    out_ready = 1'b0;
    drive(w[0], s[0], 32'h200);
    tick();
    drive(w[1], s[1], 32'h201);
    tick();
    drive(w[2], s[2], 32'h202);
    checks++;
    if (in_ready32 !== 1'b0) begin
      failures++;
      $display("FAIL skid_full got in_ready=%b expected 0", in_ready32);
    end
    tick();
    m = model(w[0], s[0], 1'b0);
    checks++;
    if (in_ready32 !== 1'b0 || out_valid32 !== 1'b1 || imm32 !== m[31:0] || tag32 !== 32'h200) begin
      failures++;
      $display("FAIL skid_hold got rdy=%b v=%b imm=%h tag=%h expected 0 1 %h 00000200",
               in_ready32, out_valid32, imm32, tag32, m[31:0]);
    end
    out_ready = 1'b1;
    tick();
    m = model(w[1], s[1], 1'b0);
    checks++;
    if (in_ready32 !== 1'b1 || imm32 !== m[31:0] || tag32 !== 32'h201) begin
      failures++;
      $display("FAIL skid_drain1 got rdy=%b imm=%h tag=%h expected 1 %h 00000201",
               in_ready32, imm32, tag32, m[31:0]);
    end
    tick();
    in_valid = 1'b0;
    m = model(w[2], s[2], 1'b0);
    checks++;
    if (out_valid32 !== 1'b1 || imm32 !== m[31:0] || tag32 !== 32'h202) begin
      failures++;
      $display("FAIL skid_third got v=%b imm=%h tag=%h expected 1 %h 00000202",
               out_valid32, imm32, tag32, m[31:0]);
    end
    tick();
    checks++;
    if (out_valid32 !== 1'b0 || sb.size() != 0) begin
      failures++;
      $display("FAIL skid_empty got v=%b pending=%0d expected 0 0", out_valid32, sb.size());
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(32'h00500093, 3'b000, 32'h300);
    tick();
    drive(32'h00600093, 3'b000, 32'h301);
    tick();
    drive(32'h00700093, 3'b000, 32'h302);
    flush = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (out_valid32 !== 1'b0 || in_ready32 !== 1'b1) begin
      failures++;
      $display("FAIL flush_state got v=%b rdy=%b expected 0 1", out_valid32, in_ready32);
    end
    out_ready = 1'b1;
    tick(); tick(); tick();
    checks++;
    if (out_valid32 !== 1'b0) begin
      failures++;
      $display("FAIL flush_leak got v=%b tag=%h expected v=0", out_valid32, tag32);
    end
  endtask

  task automatic test_bad_src();
    out_ready = 1'b1;
    drive($urandom, 3'b111, 32'h400);
    tick();
    in_valid = 1'b0;
    checks++;
    if (imm32 !== 32'h0 || imm64 !== 64'h0 || bad32 !== 1'b1 || bad64 !== 1'b1) begin
      failures++;
      $display("FAIL bad_set got imm32=%h imm64=%h bad=%b/%b expected 0 0 1/1",
               imm32, imm64, bad32, bad64);
    end
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if (bad32 !== 1'b1) begin
      failures++;
      $display("FAIL bad_sticky got bad=%b expected 1", bad32);
    end
    // stream a few words, then pull reset with entries in flight
    out_ready = 1'b0;
    drive(32'h12345013, 3'b000, 32'h410);
    tick();
    drive(32'h0010A023, 3'b001, 32'h411);
    tick();
    in_valid = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    checks++;
    if (out_valid32 !== 1'b0 || bad32 !== 1'b0 || in_ready32 !== 1'b1 || imm32 !== 32'h0 ||
        tag32 !== 32'h0 || bad64 !== 1'b0) begin
      failures++;
      $display("FAIL async_reset got v=%b bad=%b rdy=%b imm=%h tag=%h expected 0 0 1 0 0",
               out_valid32, bad32, in_ready32, imm32, tag32);
    end
    tick();
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      in_valid  = ($urandom_range(0, 2) != 0);
      instr     = $urandom;
      imm_src   = 3'($urandom_range(0, 7));
      in_tag    = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 29) == 0);
      tick();
    end
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 20 && out_valid32; c++) tick();
    checks++;
    if (out_valid32 !== 1'b0 || sb.size() != 0) begin
      failures++;
      $display("FAIL random_drain got v=%b pending=%0d expected 0 0", out_valid32, sb.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_format_i();
    test_back_to_back();
    test_xlen64();
    test_skid();
    test_flush();
    test_bad_src();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
